// File: rtl/latch_buf.sv
// In-order holding buffer that captures din on each synchronous rising edge of
// the load strobe and hands entries to a consumer through pop.
module latch_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       load,
  input  logic                       pop,
  input  logic                       clr,
  output logic [WIDTH-1:0]           go,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             load_q, load_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push;
  logic pop_acc;
  logic push_acc;
  logic wr_en;

  assign push     = load & ~load_q;
  assign pop_acc  = pop & (count_q != '0);
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push_acc = push & ((count_q != DEPTH_C) | pop_acc);
  assign wr_en    = push_acc & ~clr;

  always_comb begin
    load_d   = load;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (push_acc && !pop_acc) begin
        count_d = count_q + CNT_ONE;
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CNT_ONE;
      end
      if (push && !push_acc) begin
        ovf_d = 1'b1;
      end
    end
  end

  // load_q resets high so a strobe held through reset release is not a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      load_q   <= load_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign valid    = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign go       = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: doc/latch_buf.md
# latch_buf

Parametrised successor to the single 16-bit load latch. It captures `din` on each rising edge of the `load` strobe into a small in-order holding buffer, instead of overwriting one register. The strobe is sampled synchronously on `clk` rather than used as a clock. The buffer sits between a producer that pulses `load` and a consumer that drains entries with `pop`.

## Interface

Parameters:
- `WIDTH`, 16: data width of `din` and `go`.
- `DEPTH`, 4: number of entries. Must be a power of two and at least 2.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst`, in, 1: reset. Asynchronous, active-high.
- `din`, in, WIDTH: data captured on a detected `load` rising edge.
- `load`, in, 1: level strobe, synchronous to `clk`. Only its 0→1 transition causes a capture.
- `pop`, in, 1: removes the head entry when `valid`=1.
- `clr`, in, 1: synchronous flush of all entries and of `overflow`.
- `go`, out, WIDTH: head entry. Forced to 0 when `valid`=0.
- `valid`, out, 1: buffer holds at least one entry.
- `full`, out, 1: count == DEPTH.
- `count`, out, $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- `overflow`, out, 1: sticky. Set when a capture is dropped because the buffer was full.

## Operation

- Edge detect:
  - `load_q` is a register holding `load` from the previous cycle.
  - `push` = `load` & ~`load_q`.
  - `load` held high for N cycles produces exactly one push.
- Storage: DEPTH×WIDTH register array, write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH with natural overflow; there is no explicit compare.
- Push accepted when `push`=1 and (count < DEPTH, or `pop` accepted in the same cycle). Then `din` is written at `wr_ptr` and `wr_ptr` increments.
- Push while full with no accepted pop: data is dropped, `overflow` is set to 1, and pointers and count are unchanged.
- Pop accepted when `pop`=1 and count > 0. Then `rd_ptr` increments. Pop with count == 0 is ignored.
- Count update: count + accepted_push − accepted_pop.
  - Simultaneous accepted push and pop leaves count unchanged, including at full.
  - At count 0, push+pop: the pop is ignored and the push is accepted, so count becomes 1.
- `go` = mem[`rd_ptr`] when `valid`, else 0. It is combinational from registers.
- `clr` has priority over push/pop in the same cycle:
  - pointers and count go to 0;
  - `overflow` goes to 0;
  - the `push` in that cycle is discarded;
  - `load_q` still updates normally.
  - Memory contents are not cleared.
- `overflow` clears only on `rst` or `clr`.

## Timing

- Reset values, asynchronous on `rst`=1:
  - `count`=0, `valid`=0, `full`=0, `overflow`=0, `go`=0;
  - `wr_ptr`=`rd_ptr`=0;
  - `load_q`=1, so a `load` held high through reset release does not capture;
  - memory contents need not be reset.
- Capture latency: `load` first seen high at rising edge k writes `din` sampled at edge k. `valid`, `count`, and `go` reflect the entry after edge k, i.e. visible in cycle k+1.
- Pop latency: `pop` sampled at edge k; the next entry (or 0 if emptied) appears on `go` after edge k.
- Back-to-back captures need `load` low for at least one sampled cycle between highs. Minimum strobe period is 2 cycles.
- Reset asserted mid-operation discards all entries immediately. No partial write occurs.
- Status flags `full`, `valid`, and `count` are registered or derived from registered count. No combinational path exists from `load`, `pop`, or `din` to any output.

## Test plan

- **Reset and hold-high:** assert `rst` with `load`=1, then release and keep `load`=1 for 5 cycles → `count`=0, `valid`=0, `go`=0 throughout; first capture only after `load` drops and rises again.
- **Single capture/pop:** pulse `load` with `din`=16'hA5A5 → after the next edge `valid`=1, `count`=1, `go`=16'hA5A5. Then `pop` for 1 cycle → `valid`=0, `go`=0.
- **Fill and wrap:** DEPTH=4, capture 16'h0001..16'h0004 → `full`=1, `count`=4. Pop 2, capture 16'h0005 and 16'h0006 → pops return 3,4,5,6 in order, confirming pointer wrap.
- **Overflow:** with full buffer, pulse `load` with `din`=16'hDEAD → `count` stays 4, `overflow`=1, and 16'hDEAD is never output. `overflow` stays 1 after draining until `clr`.
- **Simultaneous edges:**
  - full buffer, `load` edge with `pop` in the same cycle → `count` stays 4, head advances, new value at tail;
  - empty buffer, push+pop → `count`=1 and the value is retained.
- **Flush priority:** with `count`=3 and `overflow`=1, assert `clr` together with a `load` edge → `count`=0, `overflow`=0, `valid`=0, and the concurrent `din` is not stored.
